// File: rtl/datapath_29.sv
// Datapath for the one-hot ASM controller: counter A, status flops E/F,
// a completion flag and a sticky trap for illegal state-line encodings.
module datapath_29 #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   s,
  input  logic [W-1:0] din,
  output logic [W-1:0] A,
  output logic         E,
  output logic         F,
  output logic         zero,
  output logic         done,
  output logic         err
);

  logic [W-1:0] a_inc;
  logic         a_inc_full;

  assign a_inc      = A + W'(1);
  assign a_inc_full = (a_inc == {W{1'b1}});
  assign zero       = (A == '0);

  // Only the seven legal one-hot codes execute; s7, all-zero and
  // multi-hot codes fall to default, hold every register and trap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      A    <= '0;
      E    <= 1'b0;
      F    <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      case (s)
        8'h01: begin
          done <= 1'b0;
        end
        8'h02: begin
          A    <= '0;
          E    <= 1'b0;
          F    <= 1'b0;
          done <= 1'b0;
        end
        8'h04: begin
          A    <= a_inc;
          E    <= a_inc[W-2];
          F    <= F | a_inc_full;
          done <= 1'b0;
        end
        8'h08: begin
          F <= 1'b1;
        end
        8'h10: begin
          E <= 1'b0;
        end
        8'h20: begin
          A <= din;
          E <= din[W-2];
        end
        8'h40: begin
          done <= 1'b1;
        end
        default: begin
          err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_29.sv
// Bench for datapath_29: directed vector table from the test plan, a reset
// mid-count sequence, and randomized stimulus against an arithmetic model.
module tb_datapath_29;
  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [7:0]   s;
  logic [W-1:0] din;
  logic [W-1:0] A;
  logic         E, F, zero, done, err;

  int n_checks = 0;
  int n_errors = 0;

  datapath_29 #(.W(W)) dut (
    .clock(clock), .reset(reset), .s(s), .din(din),
    .A(A), .E(E), .F(F), .zero(zero), .done(done), .err(err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst_n;
    logic [7:0]   s;
    logic [W-1:0] din;
    logic [W-1:0] a;
    logic         e, f, d, er;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state
  int m_a, m_e, m_f, m_d, m_err;

  task automatic add(input logic rn, input logic [7:0] sv, input logic [W-1:0] dv,
                     input logic [W-1:0] a, input logic e, input logic f,
                     input logic d, input logic er);
    vec_t v;
    v.rst_n = rn; v.s = sv; v.din = dv;
    v.a = a; v.e = e; v.f = f; v.d = d; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rn, input logic [7:0] sv, input logic [W-1:0] dv);
    reset = rn;
    s     = sv;
    din   = dv;
    @(posedge clock);
    #1;
  endtask

  function automatic void model_step(input logic rn, input logic [7:0] sv,
                                     input logic [W-1:0] dv);
    int idx;
    int modv;
    modv = 1 << W;
    if (!rn) begin
      m_a = 0; m_e = 0; m_f = 0; m_d = 0; m_err = 0;
      return;
    end
    if ($countones(sv) != 1 || sv[7]) begin
      m_err = 1;
      return;
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (sv[i]) idx = i;
    case (idx)
      0: m_d = 0;
      1: begin m_a = 0; m_e = 0; m_f = 0; m_d = 0; end
      2: begin
        m_a = (m_a + 1) % modv;
        m_e = (m_a / (modv / 4)) % 2;
        if (m_a == modv - 1) m_f = 1;
        m_d = 0;
      end
      3: m_f = 1;
      4: m_e = 0;
      5: begin m_a = int'(dv); m_e = (m_a / (modv / 4)) % 2; end
      6: m_d = 1;
      default: ;
    endcase
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".A"},    int'(A),    m_a);
    chk({tag, ".E"},    int'(E),    m_e);
    chk({tag, ".F"},    int'(F),    m_f);
    chk({tag, ".done"}, int'(done), m_d);
    chk({tag, ".err"},  int'(err),  m_err);
    chk({tag, ".zero"}, int'(zero), (m_a == 0) ? 1 : 0);
  endtask

  initial begin
    logic [7:0]   rs;
    logic [W-1:0] rd;
    logic         rr;
    reset = 1'b0;
    s     = 8'h04;
    din   = '0;

    // reset with s2 held, then s1 and three counts
    add(0, 8'h04, 0, 0, 0, 0, 0, 0);
    add(0, 8'h04, 0, 0, 0, 0, 0, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0, 0);
    add(1, 8'h04, 0, 1, 0, 0, 0, 0);
    add(1, 8'h04, 0, 2, 0, 0, 0, 0);
    add(1, 8'h04, 0, 3, 0, 0, 0, 0);
    // re-init and count through all-ones and wrap
    add(1, 8'h02, 0, 0, 0, 0, 0, 0);
    add(1, 8'h04, 0, 1, 0, 0, 0, 0);
    add(1, 8'h04, 0, 2, 0, 0, 0, 0);
    add(1, 8'h04, 0, 3, 0, 0, 0, 0);
    add(1, 8'h04, 0, 4, 1, 0, 0, 0);
    add(1, 8'h04, 0, 5, 1, 0, 0, 0);
    add(1, 8'h04, 0, 6, 1, 0, 0, 0);
    add(1, 8'h04, 0, 7, 1, 0, 0, 0);
    add(1, 8'h04, 0, 8, 0, 0, 0, 0);
    add(1, 8'h04, 0, 9, 0, 0, 0, 0);
    add(1, 8'h04, 0, 10, 0, 0, 0, 0);
    add(1, 8'h04, 0, 11, 0, 0, 0, 0);
    add(1, 8'h04, 0, 12, 1, 0, 0, 0);
    add(1, 8'h04, 0, 13, 1, 0, 0, 0);
    add(1, 8'h04, 0, 14, 1, 0, 0, 0);
    add(1, 8'h04, 0, 15, 1, 1, 0, 0);
    add(1, 8'h04, 0, 0, 0, 1, 0, 0);
    // load, clear E, set F, finish, idle
    add(1, 8'h20, 4'b0110, 6, 1, 1, 0, 0);
    add(1, 8'h10, 0, 6, 0, 1, 0, 0);
    add(1, 8'h08, 0, 6, 0, 1, 0, 0);
    add(1, 8'h40, 0, 6, 0, 1, 1, 0);
    add(1, 8'h40, 0, 6, 0, 1, 1, 0);
    add(1, 8'h01, 0, 6, 0, 1, 0, 0);
    // illegal encodings hold state and trap
    add(1, 8'h00, 0, 6, 0, 1, 0, 1);
    add(1, 8'h06, 4'hf, 6, 0, 1, 0, 1);
    add(1, 8'h80, 0, 6, 0, 1, 0, 1);
    add(1, 8'h04, 0, 7, 1, 1, 0, 1);
    // done survives s5/s4/s3, cleared by s2
    add(1, 8'h40, 0, 7, 1, 1, 1, 1);
    add(1, 8'h20, 4'b1001, 9, 0, 1, 1, 1);
    add(1, 8'h10, 0, 9, 0, 1, 1, 1);
    add(1, 8'h08, 0, 9, 0, 1, 1, 1);
    add(1, 8'h04, 0, 10, 0, 1, 0, 1);
    add(1, 8'h02, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i].rst_n, vecs[i].s, vecs[i].din);
      chk({tag, ".A"},    int'(A),    int'(vecs[i].a));
      chk({tag, ".E"},    int'(E),    int'(vecs[i].e));
      chk({tag, ".F"},    int'(F),    int'(vecs[i].f));
      chk({tag, ".done"}, int'(done), int'(vecs[i].d));
      chk({tag, ".err"},  int'(err),  int'(vecs[i].er));
      chk({tag, ".zero"}, int'(zero), (vecs[i].a == 0) ? 1 : 0);
    end

    // reset while counting at A=9 with s2 still asserted
    apply(0, 8'h00, 0); model_step(0, 8'h00, 0);
    apply(1, 8'h02, 0); model_step(1, 8'h02, 0);
    for (int i = 0; i < 9; i++) begin
      apply(1, 8'h04, 0); model_step(1, 8'h04, 0);
    end
    chk("midcnt.A_before", int'(A), 9);
    apply(1, 8'h80, 0); model_step(1, 8'h80, 0);
    chk("midcnt.err_before", int'(err), 1);
    apply(0, 8'h04, 0); model_step(0, 8'h04, 0);
    chk("midcnt.A",    int'(A),    0);
    chk("midcnt.E",    int'(E),    0);
    chk("midcnt.F",    int'(F),    0);
    chk("midcnt.err",  int'(err),  0);
    chk("midcnt.done", int'(done), 0);

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 9) == 0) rs = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 2) == 0) rs = 8'h04;
      else rs = 8'(1 << $urandom_range(0, 7));
      rd = W'($urandom);
      apply(rr, rs, rd);
      model_step(rr, rs, rd);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath_29.md
Name: datapath_29

Overview:
- Datapath unit driven by the one-hot state outputs s0..s7 of the 3-flip-flop ASM controller.
- Holds counter register A and status flip-flops E and F, and executes one micro-operation set per clock according to the active state line.
- Returns E and F to the controller as status inputs, closing the controller/datapath loop.
- Also loads external data, flags completion, and traps illegal or non-one-hot state encodings.

Parameters:
- W, 4, width of register A (W >= 3)

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-low reset
- s  input  8  one-hot state lines from controller decoder, s[0]=s0 .. s[7]=s7
- din  input  W  parallel load value for A
- A  output  W  counter register
- E  output  1  status flip-flop E, to controller
- F  output  1  status flip-flop F, to controller
- zero  output  1  combinational, 1 when A == 0
- done  output  1  registered completion flag
- err  output  1  sticky illegal-state flag

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - reset low at a rising edge forces A=0, E=0, F=0, done=0, err=0.
  - Reset overrides every s input, including mid-operation.
- Latency:
  - All registers update at the rising edge; effects are visible one cycle after the state line is sampled.
  - zero is the only combinational output.
- Legal input: exactly one bit of s high. Zero or multiple bits high is illegal: A, E, F and done hold, and err is set to 1.
- err is sticky and cleared only by reset. While err=1, operations still execute normally on legal inputs.
- Micro-operations when s is one-hot (unlisted registers hold):
  - s0 idle: hold all; done <= 0.
  - s1 init: A <= 0; E <= 0; F <= 0; done <= 0.
  - s2 count:
    - A <= A+1, mod 2^W; wraps from all-ones to 0.
    - E <= bit W-2 of the incremented value.
    - F <= F | (incremented value == all-ones).
  - s3 set F: F <= 1.
  - s4 clear E: E <= 0.
  - s5 load: A <= din; E <= din[W-2]. F is unaffected.
  - s6 finish: done <= 1; A, E, F hold.
  - s7 unused encoding: treated as illegal; hold all and set err <= 1.
- done:
  - Stays 1 across consecutive s6 cycles and through s3, s4 and s5.
  - Cleared by s0, s1 or reset.
  - s2 clears done.
- Wrap-around: counting from all-ones gives A=0 and E=0. F stays set if it was set on the previous step.
- Widths: all arithmetic is W-bit unsigned; the carry out of A is discarded.

Test Plan (W=4):
- Reset, then count to 3:
  - Hold reset low 2 cycles with s=0x04 → A=0, E=0, F=0, done=0, err=0, zero=1.
  - Release reset; apply s1 for 1 cycle, then s2 for 3 cycles → A=3, E=0, F=0, zero=0.
- Counting through 15:
  - After s1, apply s2 for 4 cycles → A=4, E=1.
  - Continue s2 to 15 total increments → A=15, E=1, F=1.
  - One more s2 → A=0, E=0, F=1.
- Load, clear and done:
  - s5 with din=4'b0110 → A=6, E=1, F unchanged.
  - Then s4 → E=0.
  - Then s3 → F=1.
  - Then s6 for 2 cycles → done=1 both cycles.
  - Then s0 → done=0.
- Illegal encodings:
  - s=8'h00, then s=8'h06, then s7, each for 1 cycle → A, E, F hold and err=1 from the first bad cycle.
  - Legal s2 afterwards increments A while err stays 1.
- Reset mid-count: during an s2 run at A=9, drive reset low with s2 still asserted → next edge A=0, E=0, F=0, err=0, done=0.
